// File: rtl/dmem_pkg.sv
// Shared types, widths and helpers for the wait-stated data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_RESP} dm_state_t;

  // One-hot byte-lane mask for a byte store at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] off);
    return 4'b0001 << off;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 word storage: per-byte write enables, synchronous write, combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [3:0]        be_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready data-memory responder with WAIT_CYCLES of latency and a one-cycle response pulse.
// Byte accesses and the req_byte port exist only when DMEM_BYTE_EN is defined.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN
  input  logic              req_byte,
`endif
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int                IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [WORD_W-1:0] LIMIT = WORD_W'(4 * DEPTH_WORDS);

  dm_state_t         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_ready_q, rsp_valid_q, rsp_err_q;
  logic [WORD_W-1:0] rsp_rdata_q;
  logic              write_q, byte_q;
  logic [WORD_W-1:0] addr_q, wdata_q;

  logic              req_byte_in;
  logic              acc_write, acc_byte, acc_err, enter_resp, wr_en;
  logic [WORD_W-1:0] acc_addr, acc_wdata, arr_rdata, arr_wdata, rd_data;
  logic [3:0]        arr_be;

`ifdef DMEM_BYTE_EN
  assign req_byte_in = req_byte;
`else
  assign req_byte_in = 1'b0;
`endif

  // With WAIT_CYCLES=0 the access happens on the accept edge, so IDLE uses the live request.
  always_comb begin
    if (state_q == DM_IDLE) begin
      acc_write = req_write;
      acc_byte  = req_byte_in;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_write = write_q;
      acc_byte  = byte_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    acc_err    = (acc_addr >= LIMIT) || (!acc_byte && (acc_addr[1:0] != 2'b00));
    enter_resp = ((state_q == DM_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                 ((state_q == DM_WAIT) && (cnt_q == CNT_W'(1)));
    wr_en      = enter_resp && acc_write && !acc_err && reset;
    arr_be     = 4'h0;
    if (wr_en) arr_be = acc_byte ? lane_mask(acc_addr[1:0]) : 4'hF;
    arr_wdata  = acc_byte ? {4{acc_wdata[7:0]}} : acc_wdata;
    rd_data    = '0;
    if (!acc_err && !acc_write) begin
      rd_data = acc_byte ? {24'h0, arr_rdata[{acc_addr[1:0], 3'b000} +: 8]} : arr_rdata;
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .idx_i   (acc_addr[IDX_W+1:2]),
    .be_i    (arr_be),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= DM_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      write_q     <= 1'b0;
      byte_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        DM_IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            byte_q      <= req_byte_in;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            cnt_q       <= CNT_W'(WAIT_CYCLES);
            req_ready_q <= 1'b0;
            state_q     <= (WAIT_CYCLES == 0) ? DM_RESP : DM_WAIT;
          end
        end
        DM_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= DM_RESP;
        end
        DM_RESP: begin
          state_q     <= DM_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= DM_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rd_data;
        rsp_err_q   <= acc_err;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
